// File: rtl/disp_num_scan_pkg.sv
// Shared constants for the 7-segment scan driver: blanking codes and the
// active-low gfedcba decode table for hex digits.
package disp_num_scan_pkg;

   localparam int CNT_W_DEF    = 32;
   localparam int SCAN_BIT_DEF = 17;

   localparam logic [3:0] AN_OFF  = 4'hF;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex7(input logic [3:0] digit);
      return HEX7_TABLE[digit];
   endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Free-running wrap-around counter; its bits serve as divided clock enables
// for the display scan and anything else needing a slow tick.
module clk_div_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] clkdiv
);

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) clkdiv <= '0;
      else     clkdiv <= clkdiv + CNT_W'(1);
   end

endmodule

// File: rtl/disp_num_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-digit
// blanking and decimal points; outputs are registered (one cycle behind sel).
module disp_num_scan
   import disp_num_scan_pkg::*;
#(
   parameter int SCAN_BIT = SCAN_BIT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] HEXS,
   input  logic [3:0]  LES,
   input  logic [3:0]  points,
   output logic [3:0]  AN,
   output logic [7:0]  Segment
);

   logic [CNT_W-1:0] clkdiv;
   logic [1:0]       sel;
   logic [3:0]       digit;
   logic [3:0]       an_next;
   logic [7:0]       seg_next;
   logic             unused_clkdiv;

   clk_div_cnt #(.CNT_W(CNT_W)) u_clk_div_cnt (
      .clk    (clk),
      .rst    (RST),
      .clkdiv (clkdiv)
   );

   assign sel           = clkdiv[SCAN_BIT+1:SCAN_BIT];
   assign unused_clkdiv = ^clkdiv;

   // NOTE: defaults first in always_comb so no path leaves a variable
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      digit    = HEXS[{sel, 2'b00} +: 4];
      an_next  = ~(4'b0001 << sel);
      seg_next = {~points[sel], hex7(digit)};
      if (LES[sel]) seg_next = SEG_OFF;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         AN      <= AN_OFF;
         Segment <= SEG_OFF;
      end else begin
         AN      <= an_next;
         Segment <= seg_next;
      end
   end

endmodule

// File: tb/tb_disp_num_scan.sv
// Directed bench for disp_num_scan with SCAN_BIT=2, CNT_W=8: each digit is
// shown for 4 clocks, the counter wraps every 256 clocks.
module tb_disp_num_scan;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] HEXS = '0;
   logic [3:0]  LES = '0;
   logic [3:0]  points = '0;
   logic [3:0]  AN;
   logic [7:0]  Segment;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [15:0] hexs;
      logic [3:0]  les;
      logic [3:0]  points;
      logic [31:0] seg;   // {digit3, digit2, digit1, digit0} expected Segment
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs [NVEC];
   logic [3:0] an_exp [4];

   disp_num_scan #(.SCAN_BIT(2), .CNT_W(8)) dut (
      .clk     (clk),
      .RST     (RST),
      .HEXS    (HEXS),
      .LES     (LES),
      .points  (points),
      .AN      (AN),
      .Segment (Segment)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] an_e, input logic [7:0] seg_e);
      n_vec++;
      if (AN !== an_e || Segment !== seg_e) begin
         n_bad++;
         $display("FAIL %s: AN=%b Segment=%h, expected AN=%b Segment=%h",
                  name, AN, Segment, an_e, seg_e);
      end
   endtask

   initial begin
      an_exp[0] = 4'b1110;
      an_exp[1] = 4'b1101;
      an_exp[2] = 4'b1011;
      an_exp[3] = 4'b0111;

      vecs[0] = '{16'h1234, 4'h0, 4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{16'hFEDC, 4'h0, 4'h0, {8'h8E, 8'h86, 8'hA1, 8'hC6}};
      vecs[2] = '{16'h5678, 4'h0, 4'h0, {8'h92, 8'h82, 8'hF8, 8'h80}};
      vecs[3] = '{16'h09AB, 4'h0, 4'h0, {8'hC0, 8'h90, 8'h88, 8'h83}};
      vecs[4] = '{16'h0000, 4'h0, 4'h0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      vecs[5] = '{16'hFFFF, 4'h0, 4'h0, {8'h8E, 8'h8E, 8'h8E, 8'h8E}};
      vecs[6] = '{16'h8888, 4'b0101, 4'hF, {8'h00, 8'hFF, 8'h00, 8'hFF}};
      vecs[7] = '{16'h0000, 4'h0, 4'b0010, {8'hC0, 8'hC0, 8'h40, 8'hC0}};
      vecs[8] = '{16'h1234, 4'hF, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};

      // Reset held for 3 cycles: outputs dark every cycle.
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", 4'hF, 8'hFF);
      end

      // Each vector: reset, load inputs, then one full scan (16 clocks).
      for (int v = 0; v < NVEC; v++) begin
         RST    = 1'b1;
         HEXS   = vecs[v].hexs;
         LES    = vecs[v].les;
         points = vecs[v].points;
         tick();
         check($sformatf("vec%0d_reset", v), 4'hF, 8'hFF);
         RST = 1'b0;
         for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("vec%0d_clk%0d", v, k), an_exp[k/4], vecs[v].seg[8*(k/4) +: 8]);
         end
      end

      // Reset asserted mid-scan while sel=2, then scan restarts at digit 0.
      HEXS = 16'h1234; LES = 4'h0; points = 4'h0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      check("mid_before_rst", 4'b1011, 8'hA4);
      RST = 1'b1;
      tick();
      check("mid_rst", 4'hF, 8'hFF);
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("mid_restart%0d", k), 4'b1110, 8'h99);
      end
      tick();
      check("mid_next_digit", 4'b1101, 8'hB0);

      // Long run across the 8-bit counter wrap: scan order must stay unbroken.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int k = 0; k < 264; k++) begin
         tick();
         check($sformatf("wrap_clk%0d", k), an_exp[(k/4)%4], vecs[0].seg[8*((k/4)%4) +: 8]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
